// File: rtl/lpc_post_fifo.sv
// lpc_post_fifo
// Snoops LPC I/O-write cycles to a contiguous window of ports starting at
// BASE_ADDR. It keeps the last byte written to each port and queues every
// captured write, tagged with its port offset, into a show-ahead FIFO.
//
// Ports:
//   lpc_clk_l   in   LPC clock; all logic on the rising edge
//   lpc_rst_l   in   synchronous active-low reset
//   lpc_frame_l in   LPC frame, active low
//   lpc_lad     in   LPC LAD bus; snooped only, never driven
//   rd_pop      in   consume FIFO head when rd_valid=1
//   ovf_clr     in   clear the sticky overflow flag
//   rd_valid    out  FIFO not empty
//   rd_data     out  FIFO head {offset, data}; holds its last value while empty
//   fifo_cnt    out  entries held, 0..DEPTH
//   overflow    out  sticky; a capture was dropped while the FIFO was full
//   lpc_hit     out  one-cycle pulse per in-range write
//   port_vals   out  last value per port; port i at [8i+7:8i]
module lpc_post_fifo #(
    parameter logic [15:0] BASE_ADDR = 16'h0080,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PORT_W    = 1,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                   lpc_clk_l,
    input  logic                   lpc_rst_l,
    input  logic                   lpc_frame_l,
    input  logic [3:0]             lpc_lad,
    input  logic                   rd_pop,
    input  logic                   ovf_clr,
    output logic                   rd_valid,
    output logic [PORT_W+7:0]      rd_data,
    output logic [CNT_W-1:0]       fifo_cnt,
    output logic                   overflow,
    output logic                   lpc_hit,
    output logic [8*NUM_PORTS-1:0] port_vals
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Reject configurations the address decode and FIFO cannot support.
    generate
        if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
            $error("lpc_post_fifo: NUM_PORTS must be 1..16");
        end
        if (PORT_W != ((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)) begin : g_bad_port_w
            $error("lpc_post_fifo: PORT_W must equal clog2(NUM_PORTS), minimum 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("lpc_post_fifo: DEPTH must be a power of two, at least 2");
        end
        if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
            $error("lpc_post_fifo: CNT_W must equal clog2(DEPTH)+1");
        end
        if ((32'(BASE_ADDR) + NUM_PORTS) > 32'h0000_FFFF) begin : g_bad_range
            $error("lpc_post_fifo: BASE_ADDR+NUM_PORTS overflows the 16-bit I/O space");
        end
    endgenerate

    typedef enum logic [3:0] {
        IDLE,
        CYC,
        A3,
        A2,
        A1,
        A0,
        D0,
        D1,
        COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]            r_addr;
    logic [7:0]             r_data;
    logic                   r_hit;
    logic                   r_overflow;
    logic [8*NUM_PORTS-1:0] r_port_vals;

    logic [PORT_W+7:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [PORT_W+7:0]      r_head;

    logic [15:0]            w_addr_diff;
    logic                   w_in_range;
    logic [PORT_W-1:0]      w_off;
    logic                   w_commit_hit;
    logic [PORT_W+7:0]      w_push_data;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [PTR_W-1:0]       w_rptr_nxt;

    // ------------------------------------------------------------------
    // Cycle decode FSM
    // ------------------------------------------------------------------
    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (!lpc_frame_l) begin
            // The last nibble seen with frame low is START, so aborts and
            // extended frames fall out of this single rule.
            w_state_nxt = (lpc_lad == 4'h0) ? CYC : IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_state_nxt = IDLE;
                CYC:     w_state_nxt = (lpc_lad[3:1] == 3'b001) ? A3 : IDLE;
                A3:      w_state_nxt = A2;
                A2:      w_state_nxt = A1;
                A1:      w_state_nxt = A0;
                A0:      w_state_nxt = D0;
                D0:      w_state_nxt = D1;
                D1:      w_state_nxt = COMMIT;
                COMMIT:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Address and data nibble capture; only meaningful on the path to COMMIT.
    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_addr <= '0;
            r_data <= '0;
        end else begin
            unique case (r_state)
                A3:      r_addr[15:12] <= lpc_lad;
                A2:      r_addr[11:8]  <= lpc_lad;
                A1:      r_addr[7:4]   <= lpc_lad;
                A0:      r_addr[3:0]   <= lpc_lad;
                D0:      r_data[3:0]   <= lpc_lad;
                D1:      r_data[7:4]   <= lpc_lad;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Address window decode
    // ------------------------------------------------------------------
    assign w_addr_diff  = r_addr - BASE_ADDR;
    assign w_in_range   = (r_addr >= BASE_ADDR) && (w_addr_diff < 16'(NUM_PORTS));
    assign w_off        = w_addr_diff[PORT_W-1:0];
    assign w_commit_hit = (r_state == COMMIT) && w_in_range;
    assign w_push_data  = {w_off, r_data};

    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_hit       <= 1'b0;
            r_port_vals <= '0;
        end else begin
            r_hit <= w_commit_hit;
            if (w_commit_hit) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (w_off == PORT_W'(i)) begin
                        r_port_vals[8*i +: 8] <= r_data;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign w_pop      = rd_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_commit_hit && (!w_full || w_pop);
    assign w_drop     = w_commit_hit && w_full && !w_pop;
    assign w_rptr_nxt = r_rptr + PTR_W'(1);

    always_ff @(posedge lpc_clk_l) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // The head is registered separately so it can hold the last popped value
    // while empty instead of exposing a stale memory slot. When the incoming
    // entry is the one that becomes head, it bypasses the memory.
    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_head <= '0;
        end else if (w_pop) begin
            if (r_cnt > CNT_W'(1)) begin
                r_head <= r_mem[w_rptr_nxt];
            end else if (w_push) begin
                r_head <= w_push_data;
            end
        end else if (w_empty && w_push) begin
            r_head <= w_push_data;
        end
    end

    always_ff @(posedge lpc_clk_l) begin
        if (!lpc_rst_l) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign rd_valid  = !w_empty;
    assign rd_data   = r_head;
    assign fifo_cnt  = r_cnt;
    assign overflow  = r_overflow;
    assign lpc_hit   = r_hit;
    assign port_vals = r_port_vals;

endmodule

// File: tb/tb_lpc_post_fifo.sv
// Directed testbench for lpc_post_fifo (BASE 0x80, 4 ports, 8-deep FIFO).
module tb_lpc_post_fifo;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        frame_l;
    logic [3:0]  lad;
    logic        rd_pop;
    logic        ovf_clr;
    logic        rd_valid;
    logic [9:0]  rd_data;
    logic [3:0]  fifo_cnt;
    logic        overflow;
    logic        lpc_hit;
    logic [31:0] port_vals;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    lpc_post_fifo #(
        .BASE_ADDR (16'h0080),
        .NUM_PORTS (4),
        .PORT_W    (2),
        .DEPTH     (8),
        .CNT_W     (4)
    ) dut (
        .lpc_clk_l   (clk),
        .lpc_rst_l   (rst_l),
        .lpc_frame_l (frame_l),
        .lpc_lad     (lad),
        .rd_pop      (rd_pop),
        .ovf_clr     (ovf_clr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fifo_cnt    (fifo_cnt),
        .overflow    (overflow),
        .lpc_hit     (lpc_hit),
        .port_vals   (port_vals)
    );

    always #5 clk = ~clk;

    // Drive one nibble, then let one rising edge pass; outputs are
    // sampled 1 ns after that edge.
    task automatic nib(input logic f, input logic [3:0] l);
        frame_l = f;
        lad     = l;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        nib(1'b1, 4'hF);
        nib(1'b1, 4'hF);
        rst_l = 1'b1;
    endtask

    // Full I/O write; returns right after the push edge. `pop` is held
    // high on that push edge only.
    task automatic lpc_write(input logic [15:0] a, input logic [7:0] d, input logic pop);
        nib(1'b0, 4'h0);
        nib(1'b1, 4'h2);
        nib(1'b1, a[15:12]);
        nib(1'b1, a[11:8]);
        nib(1'b1, a[7:4]);
        nib(1'b1, a[3:0]);
        nib(1'b1, d[3:0]);
        nib(1'b1, d[7:4]);
        rd_pop = pop;
        nib(1'b1, 4'hF);
        rd_pop = 1'b0;
    endtask

    task automatic pop_one();
        rd_pop = 1'b1;
        nib(1'b1, 4'hF);
        rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total += 6;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", rd_valid); else n_pass++;
        if (fifo_cnt !== 4'd0) $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); else n_pass++;
        if (rd_data !== 10'h000) $display("FAIL reset_rd_data got %h want 000", rd_data); else n_pass++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else n_pass++;
        if (lpc_hit !== 1'b0) $display("FAIL reset_lpc_hit got %0b want 0", lpc_hit); else n_pass++;
        if (port_vals !== 32'h0) $display("FAIL reset_port_vals got %h want 0", port_vals); else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        lpc_write(16'h0080, 8'hA5, 1'b0);
        n_total += 5;
        if (rd_valid !== 1'b1) $display("FAIL single_rd_valid got %0b want 1", rd_valid); else n_pass++;
        if (rd_data !== {2'd0, 8'hA5}) $display("FAIL single_rd_data got %h want %h", rd_data, {2'd0, 8'hA5}); else n_pass++;
        if (fifo_cnt !== 4'd1) $display("FAIL single_fifo_cnt got %0d want 1", fifo_cnt); else n_pass++;
        if (lpc_hit !== 1'b1) $display("FAIL single_hit_high got %0b want 1", lpc_hit); else n_pass++;
        if (port_vals[7:0] !== 8'hA5) $display("FAIL single_port0 got %h want a5", port_vals[7:0]); else n_pass++;
        nib(1'b1, 4'hF);
        n_total++;
        if (lpc_hit !== 1'b0) $display("FAIL single_hit_pulse got %0b want 0", lpc_hit); else n_pass++;
    endtask

    task automatic test_filtering();
        do_reset();
        lpc_write(16'h0083, 8'h3C, 1'b0);
        lpc_write(16'h0084, 8'h11, 1'b0);
        // I/O read (cycle type 0) to 0x80: must be ignored
        nib(1'b0, 4'h0);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h8);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h5);
        nib(1'b1, 4'hA);
        nib(1'b1, 4'hF);
        n_total += 4;
        if (fifo_cnt !== 4'd1) $display("FAIL filter_fifo_cnt got %0d want 1", fifo_cnt); else n_pass++;
        if (rd_data !== {2'd3, 8'h3C}) $display("FAIL filter_rd_data got %h want %h", rd_data, {2'd3, 8'h3C}); else n_pass++;
        if (port_vals[31:24] !== 8'h3C) $display("FAIL filter_port3 got %h want 3c", port_vals[31:24]); else n_pass++;
        if (port_vals[23:0] !== 24'h0) $display("FAIL filter_other_ports got %h want 0", port_vals[23:0]); else n_pass++;
    endtask

    task automatic test_abort();
        do_reset();
        nib(1'b0, 4'h0);
        nib(1'b1, 4'h2);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h0);
        // frame reasserted after A2: restarts the cycle
        lpc_write(16'h0081, 8'h77, 1'b0);
        nib(1'b1, 4'hF);
        n_total += 3;
        if (fifo_cnt !== 4'd1) $display("FAIL abort_fifo_cnt got %0d want 1", fifo_cnt); else n_pass++;
        if (rd_data !== {2'd1, 8'h77}) $display("FAIL abort_rd_data got %h want %h", rd_data, {2'd1, 8'h77}); else n_pass++;
        if (port_vals !== 32'h0000_7700) $display("FAIL abort_port_vals got %h want 00007700", port_vals); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            d = 8'(i);
            lpc_write(16'h0080, d, 1'b0);
        end
        n_total += 3;
        if (fifo_cnt !== 4'd8) $display("FAIL ovf_fifo_cnt got %0d want 8", fifo_cnt); else n_pass++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else n_pass++;
        if (port_vals[7:0] !== 8'h09) $display("FAIL ovf_port0 got %h want 09", port_vals[7:0]); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            d = 8'(i);
            n_total++;
            if (rd_data !== {2'd0, d}) $display("FAIL ovf_pop_order got %h want %h", rd_data, {2'd0, d}); else n_pass++;
            pop_one();
        end
        n_total += 3;
        if (rd_valid !== 1'b0) $display("FAIL ovf_drained_valid got %0b want 0", rd_valid); else n_pass++;
        if (rd_data !== {2'd0, 8'h08}) $display("FAIL ovf_empty_hold got %h want 008", rd_data); else n_pass++;
        pop_one();
        if (fifo_cnt !== 4'd0) $display("FAIL ovf_pop_empty got %0d want 0", fifo_cnt); else n_pass++;
        ovf_clr = 1'b1;
        nib(1'b1, 4'hF);
        ovf_clr = 1'b0;
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", overflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = 8'h10 + 8'(i);
            lpc_write(16'h0082, d, 1'b0);
        end
        lpc_write(16'h0082, 8'h55, 1'b1);
        n_total += 2;
        if (fifo_cnt !== 4'd8) $display("FAIL b2b_fifo_cnt got %0d want 8", fifo_cnt); else n_pass++;
        if (overflow !== 1'b0) $display("FAIL b2b_overflow got %0b want 0", overflow); else n_pass++;
        for (int i = 1; i < 8; i++) begin
            d = 8'h10 + 8'(i);
            n_total++;
            if (rd_data !== {2'd2, d}) $display("FAIL b2b_order got %h want %h", rd_data, {2'd2, d}); else n_pass++;
            pop_one();
        end
        n_total += 2;
        if (rd_data !== {2'd2, 8'h55}) $display("FAIL b2b_last got %h want %h", rd_data, {2'd2, 8'h55}); else n_pass++;
        if (fifo_cnt !== 4'd1) $display("FAIL b2b_last_cnt got %0d want 1", fifo_cnt); else n_pass++;
        // one entry held: push and pop together replace the head
        lpc_write(16'h0081, 8'h66, 1'b1);
        n_total += 3;
        if (rd_valid !== 1'b1) $display("FAIL b2b_one_valid got %0b want 1", rd_valid); else n_pass++;
        if (rd_data !== {2'd1, 8'h66}) $display("FAIL b2b_one_head got %h want %h", rd_data, {2'd1, 8'h66}); else n_pass++;
        if (fifo_cnt !== 4'd1) $display("FAIL b2b_one_cnt got %0d want 1", fifo_cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        lpc_write(16'h0080, 8'h01, 1'b0);
        lpc_write(16'h0081, 8'h02, 1'b0);
        lpc_write(16'h0082, 8'h03, 1'b0);
        nib(1'b0, 4'h0);
        nib(1'b1, 4'h2);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h0);
        nib(1'b1, 4'h8);
        nib(1'b1, 4'h0);
        rst_l = 1'b0;
        nib(1'b1, 4'h5);
        rst_l = 1'b1;
        n_total += 4;
        if (fifo_cnt !== 4'd0) $display("FAIL midrst_fifo_cnt got %0d want 0", fifo_cnt); else n_pass++;
        if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid got %0b want 0", rd_valid); else n_pass++;
        if (port_vals !== 32'h0) $display("FAIL midrst_port_vals got %h want 0", port_vals); else n_pass++;
        if (rd_data !== 10'h000) $display("FAIL midrst_rd_data got %h want 000", rd_data); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            nib(1'b1, (i == 0) ? 4'hA : 4'hF);
            n_total++;
            if (lpc_hit !== 1'b0) $display("FAIL midrst_no_hit got %0b want 0", lpc_hit); else n_pass++;
        end
        n_total++;
        if (fifo_cnt !== 4'd0) $display("FAIL midrst_no_push got %0d want 0", fifo_cnt); else n_pass++;
    endtask

    initial begin
        rst_l   = 1'b0;
        frame_l = 1'b1;
        lad     = 4'hF;
        rd_pop  = 1'b0;
        ovf_clr = 1'b0;
        test_reset();
        test_single_write();
        test_filtering();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
